nn_config_loader: RTL
=====================

// Module: nn_config_loader
// PURPOSE
// Hardware replacement for host-driven network configuration. Walks every layer and
// neuron, fetching weight and bias words from a preloaded config ROM and issuing
// AXI4-Lite master writes to the nn_autoGen_top register map: 0=weight, 4=bias,
// 12=layer number, 16=neuron number.
// Sits between the config ROM and the accelerator's s_axi slave. After reset, one
// start pulse fully configures the network before data is streamed in.
// PARAMETERS
// NUM_LAYERS     3                  number of layers, numbered 1..NUM_LAYERS
// LAYER_NEURONS  {8'd10,8'd30,8'd30}  packed 8b per layer; layer k at [8k-1:8k-8]
// LAYER_WEIGHTS  {10'd30,10'd30,10'd784}  packed 10b per layer; weights per neuron
// ROM_AW         15                 config ROM address width
// BIAS_BASE      24720              ROM word address of first bias word
// PORTS
// s_axi_aclk     in   1       clock
// s_axi_areset   in   1       async reset, active-high
// start          in   1       1-cycle pulse; begins configuration when idle
// busy           out  1       high from cycle after accepted start until done
// done           out  1       1-cycle pulse at end of sequence (success or abort)
// error          out  1       sticky; set on any bresp!=2'b00; cleared by next accepted start
// rom_en         out  1       ROM read strobe
// rom_addr       out  ROM_AW  ROM word address
// rom_data       in   32      ROM data, valid exactly 1 cycle after rom_en
// m_axi_awaddr   out  32      write address
// m_axi_awvalid  out  1       write-address valid
// m_axi_awready  in   1       write-address ready
// m_axi_wdata    out  32      write data
// m_axi_wstrb    out  4       tied 4'hF
// m_axi_wvalid   out  1       write-data valid
// m_axi_wready   in   1       write-data ready
// m_axi_bresp    in   2       write response
// m_axi_bvalid   in   1       response valid
// m_axi_bready   out  1       response ready
// BEHAVIOUR
// - Reset: all outputs 0 except wstrb=4'hF; state IDLE; counters 0.
// - Sequence: phase W, then phase B. Each phase runs layers k=1..NUM_LAYERS.
//   Per layer: write 12<-k.
//   Per neuron j=0..N_k-1: write 16<-j, then payload.
//   Phase W payload: W_k writes of 0<-{16'd0,rom[15:0]}. W ROM pointer starts at 0 and
//   increments once per weight, never reset between neurons or layers.
//   Phase B payload: one write 4<-rom[31:0]. B pointer starts at BIAS_BASE, increments per bias.
// - FSM states: IDLE, CTRL, FETCH, LATCH, ISSUE, RESP, NEXT, DONE.
//   IDLE: start -> CTRL (layer write).
//   CTRL: load awaddr/wdata for the layer or neuron write -> ISSUE.
//   FETCH: rom_en=1 for 1 cycle at rom_addr -> LATCH.
//   LATCH: capture rom_data into wdata -> ISSUE.
//   ISSUE: awvalid and wvalid rise together.
//     Each channel drops independently in the cycle after its own valid&ready.
//     awaddr/wdata are stable while either valid is high.
//     Both channels accepted -> RESP.
//   RESP: bready=1 until bvalid.
//     bresp!=0 -> set error and go to DONE (abort).
//     Otherwise -> NEXT.
//   NEXT: advance the j/t/k/phase counters -> CTRL, FETCH or DONE.
//   DONE: done=1, busy=0 -> IDLE.
// - Exactly one outstanding AXI transaction at a time; no address/data reordering.
// - Minimum cycles per write: control write 4 (CTRL, ISSUE, RESP, NEXT); payload write 5.
// - start while busy: ignored, no effect on counters or error.
// - Counter wrap: when the neuron counter reaches N_k-1, the next step is a new layer.
//   After layer NUM_LAYERS: phase W -> phase B; phase B -> DONE.
// - bvalid arriving the same cycle the last of aw/w is accepted: it is taken on the
//   first RESP cycle; it is never dropped.
// - Reset mid-operation: immediate return to IDLE with valids and bready deasserted.
//   Slave reset is system-level; no partial write is resumed.
// TESTING
// - Defaults, always-ready slave, start -> exactly 24936 writes.
//   First writes are (12,1), (16,0), (0,rom[0]); the last is (4,rom[24789]). done pulses once.
// - NUM_LAYERS=2, neurons {1,2}, weights {2,3}, BIAS_BASE=8 -> 21 writes.
//   Order: 12<-1, 16<-0, 3 weights, 16<-1, 3 weights, 12<-2, 16<-0, 2 weights,
//   12<-1, 16<-0, 4<-rom[8], 16<-1, 4<-rom[9], 12<-2, 16<-0, 4<-rom[10].
// - Slave with awready 3 cycles before wready, then 2-cycle bvalid delay.
//   Required: aw and w each accepted once, data stable, single bready handshake per write.
// - bresp=2'b10 on the 5th write -> error=1, done pulse, no further AW/W.
//   A new start clears error and restarts from layer 1, ROM address 0.
// - start pulses during busy -> write count and order identical to a single-start run.
// - Assert s_axi_areset while ISSUE is held -> awvalid/wvalid/busy=0 asynchronously.
//   After release, start yields a full correct sequence.

Source files
------------

// File: rtl/nn_config_loader_if.sv
// AXI4-Lite write-only channel bundle between the config loader (master)
// and the accelerator register slave.
interface nn_config_loader_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/nn_config_loader.sv
// Walks every layer/neuron, fetching weights then biases from the config ROM,
// and writes them to the accelerator register map over AXI4-Lite.
module nn_config_loader #(
    parameter int unsigned                 NUM_LAYERS    = 3,
    parameter logic [8*NUM_LAYERS-1:0]     LAYER_NEURONS = {8'd10, 8'd30, 8'd30},
    parameter logic [10*NUM_LAYERS-1:0]    LAYER_WEIGHTS = {10'd30, 10'd30, 10'd784},
    parameter int unsigned                 ROM_AW        = 15,
    parameter int unsigned                 BIAS_BASE     = 24720
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_areset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              rom_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    nn_config_loader_if.master m_axi
);

    typedef enum logic [2:0] {
        IDLE, CTRL, FETCH, LATCH, ISSUE, RESP, NEXT, DONE
    } state_e;

    typedef enum logic [1:0] {
        K_LAYER, K_NEURON, K_PAYLOAD
    } kind_e;

    state_e            state_q, state_d;
    kind_e             kind_q, kind_d;
    logic              phase_q, phase_d;
    logic [7:0]        lidx_q, lidx_d;
    logic [7:0]        nidx_q, nidx_d;
    logic [9:0]        tidx_q, tidx_d;
    logic [ROM_AW-1:0] wptr_q, wptr_d;
    logic [ROM_AW-1:0] bptr_q, bptr_d;
    logic [31:0]       awaddr_q, awaddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              error_q, error_d;

    logic              aw_valid, w_valid, b_ready;
    logic              aw_hs, w_hs, aw_ok, w_ok;
    logic [7:0]        n_cur;
    logic [9:0]        w_cur;
    logic              last_t, last_n, last_l;

    always_comb begin
        n_cur = '0;
        w_cur = '0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (32'(lidx_q) == i) begin
                n_cur = LAYER_NEURONS[8*i +: 8];
                w_cur = LAYER_WEIGHTS[10*i +: 10];
            end
        end
    end

    // Bias phase has exactly one payload word per neuron.
    assign last_t = phase_q ? 1'b1 : (tidx_q == w_cur - 10'd1);
    assign last_n = (nidx_q == n_cur - 8'd1);
    assign last_l = (lidx_q == 8'(NUM_LAYERS - 1));

    assign aw_hs = aw_valid && m_axi.awready;
    assign w_hs  = w_valid && m_axi.wready;
    assign aw_ok = aw_done_q || aw_hs;
    assign w_ok  = w_done_q || w_hs;

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = CTRL;
            CTRL:  state_d = ISSUE;
            FETCH: state_d = LATCH;
            LATCH: state_d = ISSUE;
            ISSUE: if (aw_ok && w_ok) state_d = RESP;
            RESP: begin
                if (m_axi.bvalid) begin
                    state_d = (m_axi.bresp != 2'b00) ? DONE : NEXT;
                end
            end
            NEXT: begin
                if (kind_q == K_NEURON) begin
                    state_d = FETCH;
                end else if (kind_q == K_LAYER) begin
                    state_d = CTRL;
                end else if (!last_t) begin
                    state_d = FETCH;
                end else if (last_n && last_l && phase_q) begin
                    state_d = DONE;
                end else begin
                    state_d = CTRL;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != IDLE) && (state_q != DONE);
        done     = (state_q == DONE);
        rom_en   = (state_q == FETCH);
        aw_valid = (state_q == ISSUE) && !aw_done_q;
        w_valid  = (state_q == ISSUE) && !w_done_q;
        b_ready  = (state_q == RESP);
    end

    always_comb begin
        kind_d    = kind_q;
        phase_d   = phase_q;
        lidx_d    = lidx_q;
        nidx_d    = nidx_q;
        tidx_d    = tidx_q;
        wptr_d    = wptr_q;
        bptr_d    = bptr_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        error_d   = error_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    kind_d  = K_LAYER;
                    phase_d = 1'b0;
                    lidx_d  = '0;
                    nidx_d  = '0;
                    tidx_d  = '0;
                    wptr_d  = '0;
                    bptr_d  = ROM_AW'(BIAS_BASE);
                    error_d = 1'b0;
                end
            end
            CTRL: begin
                awaddr_d  = (kind_q == K_LAYER) ? 32'd12 : 32'd16;
                wdata_d   = (kind_q == K_LAYER) ? {24'd0, lidx_q + 8'd1} : {24'd0, nidx_q};
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
            end
            FETCH: begin
                if (phase_q) begin
                    bptr_d = bptr_q + ROM_AW'(1);
                end else begin
                    wptr_d = wptr_q + ROM_AW'(1);
                end
            end
            LATCH: begin
                awaddr_d  = phase_q ? 32'd4 : 32'd0;
                wdata_d   = phase_q ? rom_data : {16'd0, rom_data[15:0]};
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
            end
            ISSUE: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
            end
            RESP: begin
                if (m_axi.bvalid && (m_axi.bresp != 2'b00)) error_d = 1'b1;
            end
            NEXT: begin
                // Step order: neuron write -> payload(s) -> next neuron / layer / phase.
                if (kind_q == K_LAYER) begin
                    kind_d = K_NEURON;
                end else if (kind_q == K_NEURON) begin
                    kind_d = K_PAYLOAD;
                    tidx_d = '0;
                end else if (!last_t) begin
                    tidx_d = tidx_q + 10'd1;
                end else if (!last_n) begin
                    nidx_d = nidx_q + 8'd1;
                    kind_d = K_NEURON;
                end else if (!last_l) begin
                    lidx_d = lidx_q + 8'd1;
                    nidx_d = '0;
                    kind_d = K_LAYER;
                end else if (!phase_q) begin
                    phase_d = 1'b1;
                    lidx_d  = '0;
                    nidx_d  = '0;
                    kind_d  = K_LAYER;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            kind_q    <= K_LAYER;
            phase_q   <= 1'b0;
            lidx_q    <= '0;
            nidx_q    <= '0;
            tidx_q    <= '0;
            wptr_q    <= '0;
            bptr_q    <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            kind_q    <= kind_d;
            phase_q   <= phase_d;
            lidx_q    <= lidx_d;
            nidx_q    <= nidx_d;
            tidx_q    <= tidx_d;
            wptr_q    <= wptr_d;
            bptr_q    <= bptr_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            error_q   <= error_d;
        end
    end

    assign error         = error_q;
    assign rom_addr      = phase_q ? bptr_q : wptr_q;
    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = 4'hF;
    assign m_axi.awvalid = aw_valid;
    assign m_axi.wvalid  = w_valid;
    assign m_axi.bready  = b_ready;

endmodule
